// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared run status encoding and default tohost address for core_run_ctrl
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5
  } run_status_t;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // Count up on inc, stick at all-ones, clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// rtl/core_run_ctrl.sv - core reset sequencing and PASS/FAIL/TIMEOUT/HANG run control; RUN_CTRL_PERF_EN enables instret
module core_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                CNT_W          = 32,
  parameter int                RST_CYCLES     = 4,
  parameter int                TIMEOUT_CYCLES = 2500,
  parameter int                STALL_CYCLES   = 64,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(TOHOST_ADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              core_rst,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] pc,
  input  logic              instr_retire,
  output logic              done,
  output logic [2:0]        status,
  output logic [DATA_W-1:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  run_status_t       state;
  run_status_t       next_state;
  logic [RST_W-1:0]  rst_cnt;
  logic [ADDR_W-1:0] prev_pc;
  logic [CNT_W-1:0]  stall_cnt;

  logic in_run;
  logic rst_done;
  logic tohost;
  logic timeout_hit;
  logic same_pc;
  logic stall_hit;

  assign in_run      = (state == ST_RUN);
  assign rst_done    = (rst_cnt == RST_W'(RST_CYCLES - 1));
  assign tohost      = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
  assign timeout_hit = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign same_pc     = (pc == prev_pc);
  assign stall_hit   = (STALL_CYCLES != 0) && same_pc &&
                       (stall_cnt == CNT_W'(STALL_CYCLES - 1));

  // State register; async reset drops straight back into RESET
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
    end else begin
      state <= next_state;
    end
  end

  // Next state: reset sequencing, then tohost > timeout > hang; terminal states hold
  always_comb begin
    next_state = state;
    unique case (state)
      ST_RESET: begin
        if (rst_done) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tohost) begin
          next_state = (mem_wdata == DATA_W'(1)) ? ST_PASS : ST_FAIL;
        end else if (timeout_hit) begin
          next_state = ST_TIMEOUT;
        end else if (stall_hit) begin
          next_state = ST_HANG;
        end
      end
      default: begin
        next_state = state;
      end
    endcase
  end

  // Counts released-reset edges while holding the core in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt <= '0;
    end else if ((state == ST_RESET) && !rst_done) begin
      rst_cnt <= rst_cnt + RST_W'(1);
    end
  end

  // Latch the failure code on the store that ends the run as FAIL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exit_code <= '0;
    end else if (in_run && (next_state == ST_FAIL)) begin
      exit_code <= mem_wdata >> 1;
    end
  end

  // Previous-cycle pc for stall detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pc <= '0;
    end else begin
      prev_pc <= pc;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_RESET),
    .inc   (in_run),
    .cnt   (cycle_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!in_run || !same_pc),
    .inc   (in_run),
    .cnt   (stall_cnt)
  );

`ifdef RUN_CTRL_PERF_EN
  sat_counter #(.WIDTH(CNT_W)) u_instret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_RESET),
    .inc   (in_run && instr_retire),
    .cnt   (instret)
  );
`else
  logic unused_instr_retire;
  assign unused_instr_retire = instr_retire;
  assign instret             = '0;
`endif

  assign core_rst = (state == ST_RESET);
  assign done     = (state != ST_RESET) && (state != ST_RUN);
  assign status   = state;

endmodule
